// File: rtl/muldiv_wb_arbiter.sv
// Writeback arbiter merging the pipelined multiplier and the iterative divider into one
// registered result port, with a starvation FSM that asks issue to pause multiplies.
module muldiv_wb_arbiter #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     mul_valid_i,
  input  logic [XLEN-1:0]          mul_result_i,
  input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
  input  logic                     div_valid_i,
  output logic                     div_ready_o,
  input  logic [XLEN-1:0]          div_result_i,
  input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
  output logic                     stall_mul_o,
  output logic [XLEN-1:0]          result_o,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  typedef enum logic [1:0] {IDLE, WAIT, STARVE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       div_fire;
  logic       div_blocked;
  logic       mul_under_stall_reg;

  // The multiplier cannot be stalled, so it always wins; a flush blocks the divider too.
  assign div_ready_o = !clr_i && !mul_valid_i;
  assign div_fire    = div_valid_i && div_ready_o;
  assign div_blocked = div_valid_i && !div_ready_o;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (clr_i) begin
      state_next = IDLE;
      cnt_next   = 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (div_blocked) begin
            cnt_next   = 4'd1;
            state_next = (LIMIT <= 4'd1) ? STARVE : WAIT;
          end
        end
        WAIT: begin
          if (div_fire || !div_valid_i) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg + 4'd1 >= LIMIT) begin
              state_next = STARVE;
            end
          end
        end
        STARVE: begin
          if (div_fire) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      stall_mul_o <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      stall_mul_o <= (state_next == STARVE);
    end
  end

  // result_o / trans_id_o keep their last value when nothing is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      result_o   <= '0;
      trans_id_o <= '0;
    end else if (clr_i) begin
      valid_o <= 1'b0;
    end else if (mul_valid_i) begin
      valid_o    <= 1'b1;
      result_o   <= mul_result_i;
      trans_id_o <= mul_trans_id_i;
    end else if (div_fire) begin
      valid_o    <= 1'b1;
      result_o   <= div_result_i;
      trans_id_o <= div_trans_id_i;
    end else begin
      valid_o <= 1'b0;
    end
  end

  // Only one in-flight multiply may land after stall_mul_o rises.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mul_under_stall_reg <= 1'b0;
    end else begin
      mul_under_stall_reg <= mul_valid_i && stall_mul_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mul_under_stall_reg && mul_valid_i && stall_mul_o));
    end
  end

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed bench for muldiv_wb_arbiter with a result scoreboard and immediate assertions.
module tb_muldiv_wb_arbiter;

  localparam int XLEN   = 64;
  localparam int IDB    = 2;
  localparam int LIMIT  = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            clr_i;
  logic            mul_valid_i;
  logic [XLEN-1:0] mul_result_i;
  logic [IDB-1:0]  mul_trans_id_i;
  logic            div_valid_i;
  logic            div_ready_o;
  logic [XLEN-1:0] div_result_i;
  logic [IDB-1:0]  div_trans_id_i;
  logic            stall_mul_o;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  logic [IDB-1:0]  trans_id_o;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [IDB-1:0]  id;
  } sb_t;

  sb_t             sb[$];
  logic [XLEN-1:0] last_res;
  logic [IDB-1:0]  last_id;
  int              checks   = 0;
  int              failures = 0;

  muldiv_wb_arbiter #(
    .XLEN(XLEN), .TRANS_ID_BITS(IDB), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i), .mul_trans_id_i(mul_trans_id_i),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_result_i(div_result_i), .div_trans_id_i(div_trans_id_i),
    .stall_mul_o(stall_mul_o), .result_o(result_o), .valid_o(valid_o), .trans_id_o(trans_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    chk(tag, 64'(div_ready_o), 64'(exp));
  endtask

  // Push whatever the current inputs should retire, clock once, then compare the output port.
  task automatic step(input string tag);
    sb_t e;
    if (!clr_i && mul_valid_i) begin
      e.res = mul_result_i; e.id = mul_trans_id_i; sb.push_back(e);
    end else if (!clr_i && div_valid_i) begin
      e.res = div_result_i; e.id = div_trans_id_i; sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(valid_o), 64'd1);
      chk({tag, "_result"}, result_o, e.res);
      chk({tag, "_id"}, 64'(trans_id_o), 64'(e.id));
      last_res = e.res;
      last_id  = e.id;
    end else begin
      chk({tag, "_valid"}, 64'(valid_o), 64'd0);
      chk({tag, "_hold_result"}, result_o, last_res);
      chk({tag, "_hold_id"}, 64'(trans_id_o), 64'(last_id));
    end
    $display("step %s: valid=%0b result=%0h id=%0d stall=%0b", tag, valid_o, result_o, trans_id_o, stall_mul_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; clr_i = 1'b0;
    mul_valid_i = 1'b0; mul_result_i = '0; mul_trans_id_i = '0;
    div_valid_i = 1'b0; div_result_i = '0; div_trans_id_i = '0;
    last_res = '0; last_id = '0;

    // Reset values
    #3;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_id", 64'(trans_id_o), 64'd0);
    chk("rst_stall", 64'(stall_mul_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Multiply only
    mul_valid_i = 1'b1; mul_result_i = 64'h1234; mul_trans_id_i = 2'd2;
    chk_ready("mul_only_ready", 1'b0);
    step("mul_only");

    // Asynchronous reset mid-cycle while valid_o is high
    mul_valid_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 64'(valid_o), 64'd0);
    chk("async_rst_stall", 64'(stall_mul_o), 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    sb.delete(); last_res = '0; last_id = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Collision: multiply wins, divide retires one cycle later
    mul_valid_i = 1'b1; mul_result_i = 64'hA; mul_trans_id_i = 2'd1;
    div_valid_i = 1'b1; div_result_i = 64'hB; div_trans_id_i = 2'd3;
    chk_ready("coll_ready_t0", 1'b0);
    step("coll_mul");
    mul_valid_i = 1'b0;
    chk_ready("coll_ready_t1", 1'b1);
    step("coll_div");
    div_valid_i = 1'b0;
    step("coll_idle");
    chk("coll_stall", 64'(stall_mul_o), 64'd0);

    // Starvation: stall after LIMIT blocked cycles, one in-flight multiply, then the divide
    div_valid_i = 1'b1; div_result_i = 64'hD1; div_trans_id_i = 2'd0;
    for (int i = 0; i < LIMIT; i++) begin
      mul_valid_i = 1'b1; mul_result_i = 64'h100 + 64'(i); mul_trans_id_i = 2'(i);
      chk_ready("starve_ready", 1'b0);
      step("starve_mul");
      chk("starve_stall", 64'(stall_mul_o), (i == LIMIT - 1) ? 64'd1 : 64'd0);
    end
    mul_result_i = 64'h1FF; mul_trans_id_i = 2'd3;
    step("starve_inflight");
    chk("starve_stall_held", 64'(stall_mul_o), 64'd1);
    mul_valid_i = 1'b0;
    chk_ready("starve_grant_ready", 1'b1);
    step("starve_div");
    chk("starve_stall_clear", 64'(stall_mul_o), 64'd0);
    div_valid_i = 1'b0;
    step("starve_idle");

    // Flush while starving with a divide pending
    div_valid_i = 1'b1; div_result_i = 64'hEE; div_trans_id_i = 2'd2;
    for (int i = 0; i < LIMIT; i++) begin
      mul_valid_i = 1'b1; mul_result_i = 64'h200 + 64'(i); mul_trans_id_i = 2'(i);
      step("flush_pre");
    end
    chk("flush_pre_stall", 64'(stall_mul_o), 64'd1);
    clr_i = 1'b1; mul_result_i = 64'h2FF;
    chk_ready("flush_ready", 1'b0);
    step("flush");
    chk("flush_stall", 64'(stall_mul_o), 64'd0);
    clr_i = 1'b0;

    // After a flush the counter restarts: LIMIT-1 blocked cycles then a handshake never stall
    for (int i = 0; i < LIMIT - 1; i++) begin
      mul_valid_i = 1'b1; mul_result_i = 64'h300 + 64'(i); mul_trans_id_i = 2'(i + 1);
      step("post_flush_mul");
      chk("post_flush_stall", 64'(stall_mul_o), 64'd0);
    end
    mul_valid_i = 1'b0;
    chk_ready("post_flush_ready", 1'b1);
    step("post_flush_div");
    chk("post_flush_div_stall", 64'(stall_mul_o), 64'd0);
    div_valid_i = 1'b0;

    // Back-to-back divides, no multiplies
    for (int i = 1; i <= 3; i++) begin
      div_valid_i = 1'b1; div_result_i = 64'h1110 * 64'(i); div_trans_id_i = 2'(i);
      chk_ready("b2b_ready", 1'b1);
      step("b2b_div");
      chk("b2b_stall", 64'(stall_mul_o), 64'd0);
    end
    div_valid_i = 1'b0;
    step("b2b_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
